// File: rtl/jc_pkg.sv
// Shared definitions for Johnson-code consumers: default sizes and tracker state encoding.
package jc_pkg;

   localparam int unsigned JC_WIDTH = 8;
   localparam int unsigned JC_ERR_W = 4;
   localparam int unsigned JC_REV_W = 8;
   localparam int unsigned PH_W     = $clog2(2 * JC_WIDTH);

   typedef enum logic {
      ST_UNLOCKED = 1'b0,
      ST_LOCKED   = 1'b1
   } state_e;

endpackage

// File: rtl/jc_classify.sv
// Combinational Johnson-code classifier: legality (at most one adjacent-bit transition) and phase decode.
module jc_classify
   import jc_pkg::*;
#(
   parameter int unsigned WIDTH = JC_WIDTH
) (
   input  logic [WIDTH-1:0]               jc_i,
   output logic                           legal_c_o,
   output logic [$clog2(2*WIDTH)-1:0]     phase_c_o
);

   localparam int unsigned PHW = $clog2(2 * WIDTH);
   localparam int unsigned CW  = PHW + 1;
   localparam logic [CW-1:0] TWO_W = CW'(2 * WIDTH);

   logic [CW-1:0] ones;
   logic          seen;
   logic          multi;

   always_comb begin
      ones      = '0;
      seen      = 1'b0;
      multi     = 1'b0;
      phase_c_o = '0;
      for (int i = 0; i < int'(WIDTH); i++) begin
         ones = ones + CW'(jc_i[i]);
      end
      for (int i = 0; i < int'(WIDTH) - 1; i++) begin
         if (jc_i[i] ^ jc_i[i+1]) begin
            if (seen) multi = 1'b1;
            seen = 1'b1;
         end
      end
      legal_c_o = ~multi;
      // Ones packed at the LSB end give phase k; ones at the top with zeros below give 2W - ones.
      if (jc_i[0] || !jc_i[WIDTH-1]) begin
         phase_c_o = PHW'(ones);
      end else begin
         phase_c_o = PHW'(TWO_W - ones);
      end
   end

endmodule

// File: rtl/johnson_phase_tracker.sv
// Tracks an upstream Johnson counter: lock FSM, continuity checking, revolution and error counters.
module johnson_phase_tracker
   import jc_pkg::*;
#(
   parameter int unsigned WIDTH = JC_WIDTH,
   parameter int unsigned ERR_W = JC_ERR_W,
   parameter int unsigned REV_W = JC_REV_W
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [WIDTH-1:0]            jc_in,
   input  logic                        jc_valid,
   input  logic                        clr_err,
   output logic [$clog2(2*WIDTH)-1:0]  phase,
   output logic                        phase_valid,
   output logic                        locked,
   output logic                        illegal,
   output logic                        skip,
   output logic                        wrap,
   output logic [REV_W-1:0]            rev_cnt,
   output logic [ERR_W-1:0]            err_cnt,
   output logic                        err_sticky
);

   localparam int unsigned PHW = $clog2(2 * WIDTH);
   localparam logic [PHW-1:0] PH_MAX = PHW'(2 * WIDTH - 1);

   state_e             state_q, state_d;
   logic [PHW-1:0]     phase_q, phase_d;
   logic               pv_q, pv_d;
   logic               ill_q, ill_d;
   logic               skip_q, skip_d;
   logic               wrap_q, wrap_d;
   logic [REV_W-1:0]   rev_q, rev_d;
   logic [ERR_W-1:0]   err_q, err_d;
   logic               sticky_q, sticky_d;

   logic               legal;
   logic [PHW-1:0]     dec_phase;
   logic [PHW-1:0]     phase_inc;
   logic               err_event;
   logic [ERR_W-1:0]   err_base;

   jc_classify #(.WIDTH(WIDTH)) u_classify (
      .jc_i      (jc_in),
      .legal_c_o (legal),
      .phase_c_o (dec_phase)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= ST_UNLOCKED;
         phase_q  <= '0;
         pv_q     <= 1'b0;
         ill_q    <= 1'b0;
         skip_q   <= 1'b0;
         wrap_q   <= 1'b0;
         rev_q    <= '0;
         err_q    <= '0;
         sticky_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         phase_q  <= phase_d;
         pv_q     <= pv_d;
         ill_q    <= ill_d;
         skip_q   <= skip_d;
         wrap_q   <= wrap_d;
         rev_q    <= rev_d;
         err_q    <= err_d;
         sticky_q <= sticky_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      phase_d   = phase_q;
      pv_d      = 1'b0;
      ill_d     = 1'b0;
      skip_d    = 1'b0;
      wrap_d    = 1'b0;
      rev_d     = rev_q;
      err_event = 1'b0;
      phase_inc = (phase_q == PH_MAX) ? '0 : phase_q + PHW'(1);

      if (jc_valid) begin
         unique case (state_q)
            ST_UNLOCKED: begin
               if (legal) begin
                  state_d = ST_LOCKED;
                  phase_d = dec_phase;
                  pv_d    = 1'b1;
               end else begin
                  ill_d     = 1'b1;
                  err_event = 1'b1;
               end
            end
            ST_LOCKED: begin
               if (!legal) begin
                  state_d   = ST_UNLOCKED;
                  ill_d     = 1'b1;
                  err_event = 1'b1;
               end else begin
                  phase_d = dec_phase;
                  pv_d    = 1'b1;
                  if (dec_phase == phase_q) begin
                     phase_d = phase_q;
                  end else if (dec_phase == phase_inc) begin
                     if (phase_q == PH_MAX) begin
                        wrap_d = 1'b1;
                        rev_d  = rev_q + REV_W'(1);
                     end
                  end else begin
                     skip_d    = 1'b1;
                     err_event = 1'b1;
                  end
               end
            end
         endcase
      end

      // Clear takes effect before the same-cycle error is added, so clear+error leaves a count of one.
      err_base = clr_err ? '0 : err_q;
      err_d    = (err_event && (err_base != '1)) ? err_base + ERR_W'(1) : err_base;
      sticky_d = (sticky_q & ~clr_err) | err_event;
   end

   assign phase       = phase_q;
   assign phase_valid = pv_q;
   assign locked      = (state_q == ST_LOCKED);
   assign illegal     = ill_q;
   assign skip        = skip_q;
   assign wrap        = wrap_q;
   assign rev_cnt     = rev_q;
   assign err_cnt     = err_q;
   assign err_sticky  = sticky_q;

endmodule

// File: doc/johnson_phase_tracker.md
Name: johnson_phase_tracker

Overview:
- Downstream consumer of the 8-bit Johnson (twisted-ring) counter stage.
- Samples each Johnson code and decodes it to a phase index 0..2W-1.
- Checks code legality and step-by-step sequence continuity, and counts full revolutions.
- Exposes lock status and error statistics for mapping onto uo_out/uio_out by the top level.

Parameters:
- WIDTH, 8, Johnson register width; 2*WIDTH legal states.
- ERR_W, 4, error counter width, saturating.
- REV_W, 8, revolution counter width, wrapping.

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  reset, synchronous, active-low
- jc_in  in  WIDTH  Johnson code from upstream counter
- jc_valid  in  1  jc_in qualifies this cycle
- clr_err  in  1  clear err_cnt and err_sticky
- phase  out  $clog2(2*WIDTH)  decoded phase of last legal sample
- phase_valid  out  1  one-cycle pulse, phase updated
- locked  out  1  tracker in LOCKED state
- illegal  out  1  one-cycle pulse, sampled code not a Johnson code
- skip  out  1  one-cycle pulse, legal code but not prev or prev+1
- wrap  out  1  one-cycle pulse, phase advanced 2W-1 -> 0
- rev_cnt  out  REV_W  revolutions since reset, wraps
- err_cnt  out  ERR_W  illegal+skip events, saturates at all-ones
- err_sticky  out  1  set on any error until clr_err

Behaviour:
- Reset (rst_n low at clk edge): state UNLOCKED; every output 0.
- Sequence definition: next = {cur[W-2:0], ~cur[W-1]}, starting from all-zeros.
- Legal code: at most one adjacent-bit transition across jc_in.
- Phase decode:
  - k ones at the LSB end, zeros above (k = 0..W) -> phase k.
  - Ones at the top with m zeros at the LSB end (m = 1..W-1) -> phase W+m.
  - Example W=8: 0x00->0, 0x01->1, 0xFF->8, 0xFE->9, 0x80->15.
- All outputs registered; latency 1 cycle from jc_valid sample to outputs.
- jc_valid low: no state change; all pulses 0.
- UNLOCKED:
  - Legal sample -> LOCKED; phase <= decoded; phase_valid=1; no continuity check; no wrap.
  - Illegal sample -> stay UNLOCKED; illegal=1; error counted.
- LOCKED:
  - Legal, decoded == phase: hold; phase_valid=1; no error.
  - Legal, decoded == (phase+1) mod 2W: advance; phase_valid=1.
    - If phase was 2W-1: wrap=1; rev_cnt+1 mod 2^REV_W.
  - Legal, any other value: resync; phase <= decoded; phase_valid=1; skip=1; error counted; stay LOCKED; no wrap.
  - Illegal: -> UNLOCKED; illegal=1; error counted; phase holds last value.
- Error accounting:
  - err_cnt_next = sat((clr_err ? 0 : err_cnt) + err_event).
  - clr_err together with an error yields err_cnt=1 and err_sticky=1.
  - err_cnt saturates at 2^ERR_W-1 and never wraps.
- rev_cnt is unaffected by clr_err; cleared only by reset.
- Reset mid-operation overrides everything in the same cycle, including jc_valid and clr_err.

Decomposition:
- Package jc_pkg:
  - state encoding constants ST_UNLOCKED=1'b0, ST_LOCKED=1'b1.
  - helper localparam PH_W = $clog2(2*WIDTH).
- Sub-module jc_classify: purely combinational; jc_in -> legal, decoded phase. Reused by future Johnson consumers.
- Top block holds the FSM, counters and registered outputs.

Test Plan:
- Reset, then 0x00,0x01,0x03 with jc_valid=1 -> locked=1 after first sample; phase 0,1,2 each one cycle later; no errors.
- 20 consecutive legal steps from 0x00 -> one wrap pulse on the 0x80->0x00 step; rev_cnt=1; phase ends at 4.
- Locked at 0x03 (phase 2), inject 0x0F (phase 4) -> skip=1; phase=4; err_cnt=1; locked stays 1.
- Locked, inject 0x05 -> illegal=1; locked=0; phase holds; next 0x07 relocks at phase 3 with no skip.
- Inject 17 illegal codes (ERR_W=4) -> err_cnt stops at 15; err_sticky=1; clr_err with a simultaneous illegal code -> err_cnt=1.
- Assert rst_n=0 mid-sequence with jc_valid=1 -> next edge: all outputs 0, UNLOCKED; rev_cnt=0.
